// File: rtl/ysyx_23060180_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060180_mem_arbiter_if
// Bundles the arbiter's three bus faces into one interface:
//   IFU side : ifu_req, ifu_addr -> ifu_gnt, ifu_rvalid, ifu_rdata
//   LSU side : lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask
//              -> lsu_gnt, lsu_done, lsu_rdata
//   MEM side : mem_rd, mem_wr, mem_addr, mem_wdata, mem_wmask <- mem_rdata
// Modports:
//   slave  - the arbiter (receives core requests, drives the memory strobes)
//   master - the environment (core requesters plus memory model)
// Parameters: ADDR_W address width, DATA_W data width (mask is DATA_W/8 bits).
// ----------------------------------------------------------------------------
interface ysyx_23060180_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    // instruction fetch
    logic              ifu_req;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_gnt;
    logic              ifu_rvalid;
    logic [DATA_W-1:0] ifu_rdata;

    // load/store
    logic              lsu_req;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_gnt;
    logic              lsu_done;
    logic [DATA_W-1:0] lsu_rdata;

    // memory
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req, ifu_addr,
        output ifu_gnt, ifu_rvalid, ifu_rdata,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_gnt, lsu_done, lsu_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    modport master (
        output ifu_req, ifu_addr,
        input  ifu_gnt, ifu_rvalid, ifu_rdata,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_gnt, lsu_done, lsu_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata
    );
endinterface

// File: rtl/ysyx_23060180_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_23060180_mem_arbiter
// Shares the core's single memory port between instruction fetch and
// load/store. One transaction in flight: grant + strobe in IDLE, wait a fixed
// MEM_LAT cycles, then pulse the owner's rvalid/done with mem_rdata passed
// through for that one cycle. Throughput is one transaction per MEM_LAT+1.
// Ports:
//   clk      clock
//   rstn_in  asynchronous active-low reset
//   bus      ysyx_23060180_mem_arbiter_if.slave (IFU, LSU and memory sides;
//            address/data widths come from the interface parameters)
// Parameters:
//   MEM_LAT  cycles from mem_rd/mem_wr to read data valid / write complete (>=1)
// Build option:
//   MEM_ARB_RR_EN  round-robin on simultaneous requests (last-grant flop);
//                  when undefined the LSU always wins a tie.
// ----------------------------------------------------------------------------
module ysyx_23060180_mem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rstn_in,
    ysyx_23060180_mem_arbiter_if.slave   bus
);
    localparam int unsigned     CNT_W     = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);
    localparam logic            OWNER_IFU = 1'b0;
    localparam logic            OWNER_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             store_q;
    logic             ifu_rvalid_q;
    logic             lsu_done_q;
`ifdef MEM_ARB_RR_EN
    logic             last_q;
`endif

    logic arb_en_c;
    logic lsu_win_c;
    logic ifu_gnt_c;
    logic lsu_gnt_c;

    // Winner selection; gated by reset so nothing is granted while held in reset
    always_comb begin
        arb_en_c  = rstn_in && (state_q == S_IDLE);
`ifdef MEM_ARB_RR_EN
        lsu_win_c = bus.lsu_req && (!bus.ifu_req || (last_q == OWNER_IFU));
`else
        lsu_win_c = bus.lsu_req;
`endif
        lsu_gnt_c = arb_en_c && lsu_win_c;
        ifu_gnt_c = arb_en_c && bus.ifu_req && !lsu_win_c;
    end

    // Request side: grant and strobe share the acceptance cycle
    assign bus.ifu_gnt   = ifu_gnt_c;
    assign bus.lsu_gnt   = lsu_gnt_c;
    assign bus.mem_rd    = ifu_gnt_c || (lsu_gnt_c && !bus.lsu_we);
    assign bus.mem_wr    = lsu_gnt_c && bus.lsu_we;
    assign bus.mem_addr  = lsu_gnt_c ? bus.lsu_addr : (ifu_gnt_c ? bus.ifu_addr : '0);
    assign bus.mem_wdata = (lsu_gnt_c && bus.lsu_we) ? bus.lsu_wdata : '0;
    assign bus.mem_wmask = (lsu_gnt_c && bus.lsu_we) ? bus.lsu_wmask : '0;

    // Response side: read data is only passed through during the owner's pulse
    assign bus.ifu_rvalid = ifu_rvalid_q;
    assign bus.ifu_rdata  = ifu_rvalid_q ? bus.mem_rdata : '0;
    assign bus.lsu_done   = lsu_done_q;
    assign bus.lsu_rdata  = (lsu_done_q && !store_q) ? bus.mem_rdata : '0;

    // Sequencer: IDLE -> (BUSY) -> RESP -> IDLE; response flags set on entry to RESP
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWNER_IFU;
            store_q      <= 1'b0;
            ifu_rvalid_q <= 1'b0;
            lsu_done_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q       <= OWNER_IFU;
`endif
        end else begin
            ifu_rvalid_q <= 1'b0;
            lsu_done_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (ifu_gnt_c || lsu_gnt_c) begin
                        owner_q <= lsu_gnt_c ? OWNER_LSU : OWNER_IFU;
                        store_q <= lsu_gnt_c && bus.lsu_we;
                        cnt_q   <= CNT_W'(1);
`ifdef MEM_ARB_RR_EN
                        last_q  <= lsu_gnt_c ? OWNER_LSU : OWNER_IFU;
`endif
                        if (MEM_LAT > 1) begin
                            state_q <= S_BUSY;
                        end else begin
                            state_q      <= S_RESP;
                            ifu_rvalid_q <= ifu_gnt_c;
                            lsu_done_q   <= lsu_gnt_c;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q      <= S_RESP;
                        ifu_rvalid_q <= (owner_q == OWNER_IFU);
                        lsu_done_q   <= (owner_q == OWNER_LSU);
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
